pipeline_exec_ctrl: RTL and testbench

Execution sequencer for the five-stage MIPS pipeline. It generates the shared stage-enable `o_valid` consumed by every stage register, including the write-back stage, from debug-unit commands. It supports three behaviours: free-run, single-step, and automatic drain on a HALT instruction so the last write-back commits before the pipeline freezes. It also keeps the executed-cycle count the debug unit reports to the host.

---
 rtl/pipeline_exec_ctrl.sv | 139 +++++++++++++
 tb/tb_pipeline_exec_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_exec_ctrl.sv
// Execution sequencer for the five-stage MIPS pipeline.
// Drives the shared stage enable from debug-unit commands (run, single-step,
// pause, clear) and drains the pipeline automatically after a HALT so the
// last write-back commits before the pipeline freezes. Also keeps the
// executed-cycle count reported to the host.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | frozen, waiting for a command
// S_RUN   | free-running, stage enable high every cycle
// S_STEP  | one enabled cycle, then back to idle
// S_DRAIN | HALT seen; DRAIN_CYCLES enabled cycles retire older instrs
// S_DONE  | program finished, only CLEAR leaves
module pipeline_exec_ctrl #(
    parameter int N_BITS       = 32,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cmd_valid,
    input  logic [1:0]        i_cmd,
    output logic              o_cmd_ready,
    input  logic              i_halt_detect,
    output logic              o_valid,
    output logic              o_flush,
    output logic              o_busy,
    output logic              o_done,
    output logic [N_BITS-1:0] o_cycle_count
);

    localparam logic [1:0] CMD_RUN   = 2'd0;
    localparam logic [1:0] CMD_STEP  = 2'd1;
    localparam logic [1:0] CMD_PAUSE = 2'd2;
    localparam logic [1:0] CMD_CLEAR = 2'd3;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STEP,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        drain_q, drain_d;
    logic              flush_q;
    logic              clear_d;
    logic              cmd_acc;
    logic              valid;
    logic [N_BITS-1:0] count_q;

    assign valid       = (state_q == S_RUN) || (state_q == S_STEP) || (state_q == S_DRAIN);
    assign o_cmd_ready = (state_q == S_IDLE) || (state_q == S_RUN) || (state_q == S_DONE);
    assign cmd_acc     = i_cmd_valid && o_cmd_ready;

    assign o_valid       = valid;
    assign o_busy        = valid;
    assign o_done        = (state_q == S_DONE);
    assign o_flush       = flush_q;
    assign o_cycle_count = count_q;

    // Next-state decode; HALT in RUN wins over a same-edge command, which is
    // still consumed and has no effect.
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        clear_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_acc) begin
                    case (i_cmd)
                        CMD_RUN:   state_d = S_RUN;
                        CMD_STEP:  state_d = S_STEP;
                        CMD_CLEAR: clear_d = 1'b1;
                        default:   state_d = S_IDLE;
                    endcase
                end
            end
            S_RUN: begin
                if (i_halt_detect) begin
                    state_d = S_DRAIN;
                    drain_d = DRAIN_LOAD;
                end else if (cmd_acc && (i_cmd == CMD_PAUSE)) begin
                    state_d = S_IDLE;
                end else if (cmd_acc && (i_cmd == CMD_CLEAR)) begin
                    state_d = S_IDLE;
                    clear_d = 1'b1;
                end
            end
            S_STEP: begin
                if (i_halt_detect) begin
                    state_d = S_DRAIN;
                    drain_d = DRAIN_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (drain_q == 4'd0) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q - 4'd1;
                end
            end
            S_DONE: begin
                if (cmd_acc && (i_cmd == CMD_CLEAR)) begin
                    state_d = S_IDLE;
                    clear_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, drain down-counter and flush pulse registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            drain_q <= 4'd0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            flush_q <= clear_d;
        end
    end

    // Executed-cycle counter: saturating, CLEAR beats the increment.
    always_ff @(posedge i_clk) begin
        if (i_reset || clear_d) begin
            count_q <= '0;
        end else if (valid && (count_q != {N_BITS{1'b1}})) begin
            count_q <= count_q + N_BITS'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Directed bench for pipeline_exec_ctrl. Each step drives one cycle of
// inputs, queues the outputs expected after the next rising edge, then pops
// and compares them. A second instance with a 4-bit counter shares the
// stimulus; its count is expected to be the main count clipped at 15.
module tb_pipeline_exec_ctrl;

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] STEP  = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;
    localparam logic [1:0] CLEAR = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd = RUN;
    logic        halt = 1'b0;
    logic        cmd_ready, valid, flush, busy, done;
    logic [31:0] count;
    logic        s_cmd_ready, s_valid, s_flush, s_busy, s_done;
    logic [3:0]  s_count;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       tag;
        logic        v;
        logic        r;
        logic        f;
        logic        d;
        logic [31:0] c;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    pipeline_exec_ctrl #(.N_BITS(32), .DRAIN_CYCLES(4)) dut (
        .i_clk(clk), .i_reset(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
        .o_cmd_ready(cmd_ready), .i_halt_detect(halt), .o_valid(valid),
        .o_flush(flush), .o_busy(busy), .o_done(done), .o_cycle_count(count)
    );

    pipeline_exec_ctrl #(.N_BITS(4), .DRAIN_CYCLES(4)) dut_sat (
        .i_clk(clk), .i_reset(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
        .o_cmd_ready(s_cmd_ready), .i_halt_detect(halt), .o_valid(s_valid),
        .o_flush(s_flush), .o_busy(s_busy), .o_done(s_done), .o_cycle_count(s_count)
    );

    task automatic chk(input string tag, input string field,
                       input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
        end
    endtask

    // One cycle: drive inputs, queue expectation, step past the edge, compare.
    task automatic cyc(input string tag, input logic cv, input logic [1:0] c,
                       input logic h, input logic r,
                       input logic ev, input logic er, input logic ef,
                       input logic ed, input logic [31:0] ec);
        exp_t e;
        cmd_valid = cv;
        cmd       = c;
        halt      = h;
        rst       = r;
        sb.push_back('{tag, ev, er, ef, ed, ec});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s.queue observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk(e.tag, "valid", 32'(valid), 32'(e.v));
            chk(e.tag, "busy", 32'(busy), 32'(e.v));
            chk(e.tag, "ready", 32'(cmd_ready), 32'(e.r));
            chk(e.tag, "flush", 32'(flush), 32'(e.f));
            chk(e.tag, "done", 32'(done), 32'(e.d));
            chk(e.tag, "count", count, e.c);
            chk(e.tag, "sat_count", 32'(s_count), (e.c > 32'd15) ? 32'd15 : e.c);
        end
    endtask

    initial begin
        // Reset held with RUN presented: nothing accepted.
        for (int i = 0; i < 3; i++) cyc("reset", 1, RUN, 0, 1, 0, 1, 0, 0, 0);
        cyc("run_acc", 1, RUN, 0, 0, 1, 1, 0, 0, 0);
        for (int i = 1; i <= 9; i++) cyc("run", 0, RUN, 0, 0, 1, 1, 0, 0, 32'(i));
        cyc("pause", 1, PAUSE, 0, 0, 0, 1, 0, 0, 10);
        cyc("idle", 0, RUN, 0, 0, 0, 1, 0, 0, 10);

        // Back-to-back STEP.
        cyc("clear0", 1, CLEAR, 0, 0, 0, 1, 1, 0, 0);
        cyc("step1", 1, STEP, 0, 0, 1, 0, 0, 0, 0);
        cyc("step1_gap", 1, STEP, 0, 0, 0, 1, 0, 0, 1);
        cyc("step2", 1, STEP, 0, 0, 1, 0, 0, 0, 1);
        cyc("step2_gap", 1, STEP, 0, 0, 0, 1, 0, 0, 2);
        cyc("step3", 1, STEP, 0, 0, 1, 0, 0, 0, 2);
        cyc("step_end", 0, STEP, 0, 0, 0, 1, 0, 0, 3);

        // HALT on the 6th enabled cycle, then drain and DONE.
        cyc("clear1", 1, CLEAR, 0, 0, 0, 1, 1, 0, 0);
        cyc("h_run", 1, RUN, 0, 0, 1, 1, 0, 0, 0);
        for (int i = 1; i <= 5; i++) cyc("h_run_n", 0, RUN, 0, 0, 1, 1, 0, 0, 32'(i));
        cyc("h_drain1", 0, RUN, 1, 0, 1, 0, 0, 0, 6);
        cyc("h_drain2", 0, RUN, 0, 0, 1, 0, 0, 0, 7);
        cyc("h_drain3", 0, RUN, 1, 0, 1, 0, 0, 0, 8);
        cyc("h_drain4", 0, RUN, 0, 0, 1, 0, 0, 0, 9);
        cyc("h_done", 0, RUN, 0, 0, 0, 1, 0, 1, 10);
        cyc("done_run", 1, RUN, 0, 0, 0, 1, 0, 1, 10);
        cyc("done_step", 1, STEP, 0, 0, 0, 1, 0, 1, 10);
        cyc("done_pause", 1, PAUSE, 1, 0, 0, 1, 0, 1, 10);
        cyc("done_clear", 1, CLEAR, 0, 0, 0, 1, 1, 0, 0);
        cyc("post_clear", 0, RUN, 0, 0, 0, 1, 0, 0, 0);

        // HALT beats PAUSE on the same edge.
        cyc("c_run", 1, RUN, 0, 0, 1, 1, 0, 0, 0);
        cyc("c_run2", 0, RUN, 0, 0, 1, 1, 0, 0, 1);
        cyc("c_halt_pause", 1, PAUSE, 1, 0, 1, 0, 0, 0, 2);
        cyc("c_drain2", 0, RUN, 0, 0, 1, 0, 0, 0, 3);
        cyc("c_drain3", 0, RUN, 0, 0, 1, 0, 0, 0, 4);
        cyc("c_drain4", 0, RUN, 0, 0, 1, 0, 0, 0, 5);
        cyc("c_done", 0, RUN, 0, 0, 0, 1, 0, 1, 6);
        cyc("c_clear", 1, CLEAR, 0, 0, 0, 1, 1, 0, 0);

        // HALT beats CLEAR on the same edge: no flush, count kept.
        cyc("hc_run", 1, RUN, 0, 0, 1, 1, 0, 0, 0);
        cyc("hc_halt_clear", 1, CLEAR, 1, 0, 1, 0, 0, 0, 1);
        cyc("hc_drain2", 0, RUN, 0, 0, 1, 0, 0, 0, 2);
        cyc("hc_drain3", 0, RUN, 0, 0, 1, 0, 0, 0, 3);
        cyc("hc_drain4", 0, RUN, 0, 0, 1, 0, 0, 0, 4);
        cyc("hc_done", 0, RUN, 0, 0, 0, 1, 0, 1, 5);
        cyc("hc_clear", 1, CLEAR, 0, 0, 0, 1, 1, 0, 0);

        // HALT seen during the single STEP cycle.
        cyc("sh_step", 1, STEP, 0, 0, 1, 0, 0, 0, 0);
        cyc("sh_halt", 0, RUN, 1, 0, 1, 0, 0, 0, 1);
        cyc("sh_drain2", 0, RUN, 0, 0, 1, 0, 0, 0, 2);
        cyc("sh_drain3", 0, RUN, 0, 0, 1, 0, 0, 0, 3);
        cyc("sh_drain4", 0, RUN, 0, 0, 1, 0, 0, 0, 4);
        cyc("sh_done", 0, RUN, 0, 0, 0, 1, 0, 1, 5);
        cyc("sh_clear", 1, CLEAR, 0, 0, 0, 1, 1, 0, 0);

        // Reset in the 2nd DRAIN cycle, then a full drain afterwards.
        cyc("mr_run", 1, RUN, 0, 0, 1, 1, 0, 0, 0);
        cyc("mr_halt", 0, RUN, 1, 0, 1, 0, 0, 0, 1);
        cyc("mr_drain2", 0, RUN, 0, 0, 1, 0, 0, 0, 2);
        cyc("mr_reset", 1, STEP, 0, 1, 0, 1, 0, 0, 0);
        cyc("mr_idle", 0, RUN, 0, 0, 0, 1, 0, 0, 0);
        cyc("mr_run2", 1, RUN, 0, 0, 1, 1, 0, 0, 0);
        cyc("mr_halt2", 0, RUN, 1, 0, 1, 0, 0, 0, 1);
        cyc("mr_d2", 0, RUN, 0, 0, 1, 0, 0, 0, 2);
        cyc("mr_d3", 0, RUN, 0, 0, 1, 0, 0, 0, 3);
        cyc("mr_d4", 0, RUN, 0, 0, 1, 0, 0, 0, 4);
        cyc("mr_done", 0, RUN, 0, 0, 0, 1, 0, 1, 5);

        // Saturation: 4-bit instance must hold at 15.
        cyc("sat_clear", 1, CLEAR, 0, 0, 0, 1, 1, 0, 0);
        cyc("sat_run", 1, RUN, 0, 0, 1, 1, 0, 0, 0);
        for (int i = 1; i <= 20; i++) cyc("sat_run_n", 0, RUN, 0, 0, 1, 1, 0, 0, 32'(i));
        cyc("sat_pause", 1, PAUSE, 0, 0, 0, 1, 0, 0, 21);
        cyc("sat_idle", 0, RUN, 0, 0, 0, 1, 0, 0, 21);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
